// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing helpers for the FIFO read-drain stage.
package fifo_drain_pkg;

  localparam int unsigned DATA_W_DEF = 128;

  typedef logic [DATA_W_DEF-1:0] data_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_skid_buf.sv
// Circular skid buffer: push at wr_ptr, pop at rd_ptr, head is registered storage.
module fifo_drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned PW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [PW:0]       occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      occ <= occ + (PW+1)'(1);
      else if (!push && pop) occ <= occ - (PW+1)'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a sync FIFO into a valid/ready stream; reads are throttled so returning data always fits.
module fifo_rd_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned SKID_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rddata,
  output logic              fifo_rden,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              idle
);

  localparam int unsigned PW = ptr_w(SKID_DEPTH);
  localparam int unsigned SW = PW + 3;

  logic [RD_LAT-1:0] rd_vld;
  logic [PW:0]       occ;
  logic [SW-1:0]     inflight;
  logic [SW-1:0]     pending;
  logic              pop;
  logic              capture;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + SW'(rd_vld[i]);
  end

  assign pop     = m_valid && m_ready;
  assign capture = rd_vld[RD_LAT-1];
  // Buffered + outstanding beats after this edge; a read is only issued if its data will fit.
  assign pending   = SW'(occ) + inflight - SW'(pop);
  assign fifo_rden = !reset && enable && !fifo_empty && (pending < SW'(SKID_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld   <= '0;
      beat_cnt <= '0;
    end else begin
      rd_vld[0] <= fifo_rden;
      for (int unsigned i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
      if (pop) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  fifo_drain_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (fifo_rddata),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != '0);
  assign idle    = !fifo_rden && (inflight == '0) && (occ == '0);

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Scoreboard bench: lane 0 is RD_LAT=1/SKID=2/CNT_W=32, lane 1 is RD_LAT=3/SKID=4/CNT_W=4 (wraps).
`timescale 1ns/1ps
module tb_fifo_rd_drain;

  localparam int unsigned DW = 128;
  localparam int unsigned NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [NL];
  logic          en    [NL];
  logic          rdy   [NL];
  logic          empty [NL];
  logic [DW-1:0] rddata[NL];
  logic          rden  [NL];
  logic          mv    [NL];
  logic [DW-1:0] md    [NL];
  logic          idl   [NL];
  logic [31:0]   bcw   [NL];

  logic [DW-1:0] fq  [NL][$];
  logic [DW-1:0] exq [NL][$];
  int unsigned   acc [NL];
  int unsigned   nrd [NL];
  int            first_rd [NL];
  int            first_beat [NL];
  int            last_beat [NL];
  logic          idle_s [NL];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned L = (g == 0) ? 1 : 3;
    localparam int unsigned S = (g == 0) ? 2 : 4;
    localparam int unsigned C = (g == 0) ? 32 : 4;

    logic [C-1:0]  bc;
    logic [DW-1:0] pipe [L];
    logic          rd_seen = 1'b0;
    logic          stall   = 1'b0;
    logic [DW-1:0] held;
    int            outstanding = 0;

    fifo_rd_drain #(
      .DATA_W     (DW),
      .RD_LAT     (L),
      .SKID_DEPTH (S),
      .CNT_W      (C)
    ) dut (
      .clk         (clk),
      .reset       (rst[g]),
      .enable      (en[g]),
      .fifo_empty  (empty[g]),
      .fifo_rddata (rddata[g]),
      .fifo_rden   (rden[g]),
      .m_valid     (mv[g]),
      .m_ready     (rdy[g]),
      .m_data      (md[g]),
      .beat_cnt    (bc),
      .idle        (idl[g])
    );

    assign bcw[g] = 32'(bc);

    // FIFO with registered empty flag and L-cycle read latency; junk data in idle slots.
    always @(posedge clk) begin
      logic [DW-1:0] d;
      if (rst[g]) begin
        for (int i = 0; i < int'(L); i++) pipe[i] = '0;
        rddata[g] <= '0;
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
        if (rd_seen && fq[g].size() > 0) d = fq[g].pop_front();
        for (int i = int'(L) - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = d;
        rddata[g] <= pipe[L-1];
      end
      empty[g] <= (fq[g].size() == 0);
    end

    always @(negedge clk) begin
      if (rst[g]) begin
        rd_seen     = 1'b0;
        stall       = 1'b0;
        outstanding = 0;
      end else begin
        if (empty[g]) check($sformatf("L%0d_rden_while_empty", g), DW'(rden[g]), '0);
        check($sformatf("L%0d_beat_cnt", g), DW'(bc), DW'(C'(acc[g])));
        if (stall) begin
          check($sformatf("L%0d_hold_valid", g), DW'(mv[g]), DW'(1));
          check($sformatf("L%0d_hold_data", g), md[g], held);
        end
        if (mv[g] && rdy[g]) begin
          if (exq[g].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL L%0d_stray_beat: got %0h expected no beat", g, md[g]);
          end else begin
            check($sformatf("L%0d_data", g), md[g], exq[g].pop_front());
          end
          acc[g]++;
          if (first_beat[g] < 0) first_beat[g] = cyc;
          last_beat[g] = cyc;
          outstanding--;
        end
        if (rden[g]) begin
          nrd[g]++;
          outstanding++;
          if (first_rd[g] < 0) first_rd[g] = cyc;
        end
        check($sformatf("L%0d_skid_overflow", g), DW'(outstanding > int'(S)), '0);
        stall   = mv[g] && !rdy[g];
        held    = md[g];
        rd_seen = rden[g];
        idle_s[g] = idl[g];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [DW-1:0] d);
    fq[g].push_back(d);
    exq[g].push_back(d);
  endtask

  task automatic do_reset(input int g);
    @(negedge clk);
    #2;
    rst[g] = 1'b1;
    fq[g].delete();
    exq[g].delete();
    acc[g] = 0;
    nrd[g] = 0;
    first_rd[g] = -1;
    first_beat[g] = -1;
    last_beat[g] = -1;
    #1;
    check($sformatf("L%0d_rst_m_valid", g), DW'(mv[g]), '0);
    check($sformatf("L%0d_rst_beat_cnt", g), DW'(bcw[g]), '0);
    check($sformatf("L%0d_rst_idle", g), DW'(idl[g]), DW'(1));
    check($sformatf("L%0d_rst_rden", g), DW'(rden[g]), '0);
    check($sformatf("L%0d_rst_m_data", g), md[g], '0);
    @(negedge clk);
    #2;
    rst[g] = 1'b0;
    step(1);
  endtask

  task automatic wait_drain(input int g, input int budget);
    int n = 0;
    while ((exq[g].size() != 0 || !idle_s[g]) && n < budget) begin
      step(1);
      n++;
    end
    step(1);
    check($sformatf("L%0d_drain_left", g), DW'(exq[g].size()), '0);
    check($sformatf("L%0d_idle_end", g), DW'(idle_s[g]), DW'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pushed;
    for (int g = 0; g < int'(NL); g++) begin
      rst[g] = 1'b1; en[g] = 1'b0; rdy[g] = 1'b0; idle_s[g] = 1'b1;
      acc[g] = 0; nrd[g] = 0;
      first_rd[g] = -1; first_beat[g] = -1; last_beat[g] = -1;
    end
    step(2);
    do_reset(0);

    // Reset mid-stream: buffered and in-flight beats vanish.
    for (int i = 1; i <= 4; i++) push(0, DW'(i));
    en[0] = 1'b1; rdy[0] = 1'b1;
    step(4);
    do_reset(0);
    step(10);
    check("rst_no_new_reads", DW'(nrd[0]), '0);
    check("rst_idle_after", DW'(idle_s[0]), DW'(1));

    // Streaming 1..8 with ready held high.
    en[0] = 1'b0;
    do_reset(0);
    for (int i = 1; i <= 8; i++) push(0, DW'(i));
    en[0] = 1'b1; rdy[0] = 1'b1;
    wait_drain(0, 100);
    check("stream_count", DW'(bcw[0]), DW'(8));
    check("stream_latency", DW'(first_beat[0] - first_rd[0]), DW'(2));
    check("stream_b2b", DW'(last_beat[0] - first_beat[0]), DW'(7));

    // Back-pressure: only SKID_DEPTH reads while stalled, head holds.
    en[0] = 1'b0; rdy[0] = 1'b0;
    do_reset(0);
    for (int i = 1; i <= 6; i++) push(0, DW'(i));
    en[0] = 1'b1;
    step(5);
    check("bp_reads", DW'(nrd[0]), DW'(2));
    check("bp_head", md[0], DW'(1));
    rdy[0] = 1'b1;
    wait_drain(0, 100);
    check("bp_count", DW'(bcw[0]), DW'(6));
    check("bp_total_reads", DW'(nrd[0]), DW'(6));

    // Single beat across the empty boundary.
    en[0] = 1'b0;
    do_reset(0);
    en[0] = 1'b1; rdy[0] = 1'b1;
    step(3);
    check("empty_no_reads", DW'(nrd[0]), '0);
    push(0, DW'(8'hA5));
    wait_drain(0, 50);
    check("empty_one_read", DW'(nrd[0]), DW'(1));
    check("empty_one_beat", DW'(bcw[0]), DW'(1));

    // Enable drop after three reads.
    en[0] = 1'b0;
    do_reset(0);
    for (int i = 1; i <= 10; i++) push(0, DW'(32'h100 + i));
    en[0] = 1'b1; rdy[0] = 1'b1;
    n = 0;
    while (nrd[0] < 3 && n < 50) begin
      step(1);
      n++;
    end
    en[0] = 1'b0;
    step(10);
    check("endrop_reads", DW'(nrd[0]), DW'(3));
    check("endrop_count", DW'(bcw[0]), DW'(3));
    check("endrop_fifo_left", DW'(fq[0].size()), DW'(7));
    check("endrop_idle", DW'(idle_s[0]), DW'(1));
    en[0] = 1'b1;
    wait_drain(0, 100);
    check("endrop_final", DW'(bcw[0]), DW'(10));

    // Random ready and random arrivals on the deep-latency lane; 4-bit count wraps.
    do_reset(1);
    en[1] = 1'b1;
    pushed = 0;
    n = 0;
    while ((pushed < 1000 || exq[1].size() != 0) && n < 20000) begin
      rdy[1] = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 9) < 6) begin
        push(1, {$urandom, $urandom, $urandom, $urandom});
        pushed++;
      end
      step(1);
      n++;
    end
    rdy[1] = 1'b1;
    wait_drain(1, 200);
    check("rand_beats", DW'(acc[1]), DW'(1000));
    check("rand_wrap_cnt", DW'(bcw[1]), DW'(1000 % 16));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Downstream consumer of the 128-bit sync FIFO.
- Issues read strobes to the FIFO while it is non-empty and local space is available, and captures read data returned RD_LAT cycles later into a small skid buffer.
- Presents that data as a valid/ready stream to the next stage.
- Guarantees no beat is dropped or duplicated under arbitrary back-pressure.

Parameters:
- DATA_W, 128, width of FIFO read data and stream data.
- RD_LAT, 1, cycles from FIFO read strobe to read data valid; legal values 1..3.
- SKID_DEPTH, 2, skid buffer entries; must be >= RD_LAT+1 for full throughput; power of two.
- CNT_W, 32, width of the drained-beat counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, new FIFO reads may be issued.
- fifo_empty  in  1  FIFO empty flag (connects to o_empty).
- fifo_rddata  in  DATA_W  FIFO read data (connects to o_rddata).
- fifo_rden  out  1  FIFO read strobe (connects to i_rden).
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  DATA_W  output stream data.
- beat_cnt  out  CNT_W  count of beats accepted downstream; wraps modulo 2^CNT_W.
- idle  out  1  high when the block holds no data and nothing is in flight.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high, named reset.
- Reset values (asserted asynchronously, released on next edge):
  - fifo_rden=0, m_valid=0, m_data=0, beat_cnt=0, idle=1.
  - In-flight pipe, skid occupancy and pointers are cleared.
  - Data in flight at reset is discarded.
- In-flight tracking:
  - RD_LAT-deep shift register of read-valid bits.
  - inflight = popcount of the shift register.
- Pop:
  - pop = m_valid && m_ready.
- Issue:
  - fifo_rden = enable && !fifo_empty && (occ + inflight - pop) < SKID_DEPTH.
  - fifo_rden is combinational from registered state and inputs, so it asserts in the same cycle as the FIFO's empty flag drops.
  - Never assert fifo_rden when fifo_empty=1.
- Capture:
  - When the last stage of the read-valid pipe is 1, write fifo_rddata into the skid buffer at wr_ptr; occ increments.
  - Space is guaranteed by the issue rule; overflow is impossible and is a bench assertion.
- Output:
  - m_valid = (occ != 0).
  - m_data = buf[rd_ptr], registered storage, no combinational path from fifo_rddata.
  - On pop: rd_ptr++, occ--, beat_cnt++.
- Simultaneous capture and pop: occ unchanged, both pointers advance.
- Pointer width: log2(SKID_DEPTH); wraps naturally. occ width: log2(SKID_DEPTH)+1.
- Stream rules:
  - Once m_valid=1, m_valid and m_data hold until pop.
  - Stream order equals FIFO read order.
- enable deasserted mid-operation:
  - No new reads are issued.
  - In-flight reads still complete into the buffer.
  - Buffered data keeps draining.
- idle = !fifo_rden && inflight==0 && occ==0.
- Throughput: with SKID_DEPTH>=RD_LAT+1, m_ready held high and FIFO non-empty, one beat per cycle in steady state.
- Latency: first beat appears on m_valid RD_LAT+1 cycles after the first fifo_rden = 1 cycle.

Decomposition:
- Package fifo_drain_pkg:
  - DATA_W default constant.
  - typedef data_t (logic [DATA_W-1:0]).
  - Function clog2-based pointer width helper.
- Sub-module: fifo_drain_skid_buf, the SKID_DEPTH-entry circular buffer with occ/pointers, push/pop ports and head data out.
- The top holds the issue logic, read-valid pipe and beat counter.

Test Plan:
- Reset mid-stream: write 4 beats, start draining, assert reset for 1 cycle -> m_valid=0 and beat_cnt=0 immediately (async), idle=1, no stale beat after release.
- Streaming: FIFO holds 0x1..0x8, m_ready=1, RD_LAT=1, SKID_DEPTH=2 -> beats 0x1..0x8 in order, back-to-back after 2-cycle latency, beat_cnt=8, idle=1 at end.
- Back-pressure: 6 beats queued, m_ready low 5 cycles then high -> fifo_rden issues exactly 2 reads then stops, m_data holds 0x1 stable, all 6 beats then delivered with no loss or duplication.
- Empty boundary: FIFO receives a single beat 0xA5 -> exactly one fifo_rden pulse, fifo_rden never high while fifo_empty=1, m_data=0xA5 for one accepted beat.
- enable drop: 10 beats queued, enable falls after 3 reads -> in-flight beats still delivered, beat_cnt stops at 3, fifo_rden stays low; on re-enable the remaining 7 follow.
- Random m_ready (50%) with RD_LAT=3, SKID_DEPTH=4, 1000 beats -> scoreboard order match and no skid overflow assertion.
- Separate wrap run: beat_cnt preset near 2^CNT_W-1 via a forced start value in the bench -> count wraps to 0.
